// File: rtl/test_tx.sv
// test_tx: test-pattern frame generator for the MAC transmit byte interface.
// Payload is the byte stream of a 16-bit LFSR scrambler (x^16+x^15+x^13+x^4+1),
// seeded once per session, so consecutive frames form one unbroken sequence.
// Optional build macro TEST_TX_ERR_INJ_EN adds err_inj, a one-shot that flips
// bit 0 of the first byte of the next frame.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no session; outputs quiet
// SEED    | one cycle: reload scrambler with G_INIT_VAL, latch frame length
// PAYLOAD | presenting bytes; advance on valid && rdy
// GAP     | inter-frame idle, ifg_len + 1 cycles

module sata_scrambler #(
  parameter logic [15:0] G_INIT_VAL = 16'h55AA
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p_in_SOF,
  input  logic       p_in_en,
  output logic [7:0] p_out_result
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Eight serial LFSR steps per accepted byte; newest bit enters at bit 0.
  function automatic logic [15:0] adv8(input logic [15:0] s);
    logic [15:0] t;
    t = s;
    for (int i = 0; i < 8; i++) begin
      t = {t[14:0], t[15] ^ t[14] ^ t[12] ^ t[3]};
    end
    return t;
  endfunction

  // Reseed has priority over advance; otherwise hold so the byte stays stable.
  always_comb begin
    lfsr_d = lfsr_q;
    if (p_in_SOF) begin
      lfsr_d = G_INIT_VAL;
    end else if (p_in_en) begin
      lfsr_d = adv8(lfsr_q);
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= G_INIT_VAL;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign p_out_result = lfsr_q[7:0];

endmodule

module test_tx #(
  parameter logic [15:0] G_INIT_VAL = 16'h55AA,
  parameter int          G_CNT_W    = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [15:0]        frame_len,
  input  logic [7:0]         ifg_len,
`ifdef TEST_TX_ERR_INJ_EN
  input  logic               err_inj,
`endif
  output logic [7:0]         mac_tx_data,
  output logic               mac_tx_valid,
  output logic               mac_tx_sof,
  output logic               mac_tx_eof,
  input  logic               mac_tx_rdy,
  output logic               busy,
  output logic [G_CNT_W-1:0] frame_cnt
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SEED    = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;
  localparam logic [1:0] S_GAP     = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [15:0]        len_q, len_d;
  logic [15:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]         ifg_cnt_q, ifg_cnt_d;
  logic [G_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic        accept;
  logic        last_byte;
  logic        first_byte;
  logic [15:0] frame_len_eff;
  logic [7:0]  scr_byte;
  logic        inj_bit;

  assign frame_len_eff = (frame_len == 16'd0) ? 16'd1 : frame_len;
  assign accept        = (state_q == S_PAYLOAD) && mac_tx_rdy;
  assign first_byte    = (byte_cnt_q == 16'd0);
  assign last_byte     = (byte_cnt_q == (len_q - 16'd1));

  sata_scrambler #(
    .G_INIT_VAL(G_INIT_VAL)
  ) u_scr (
    .clk         (clk),
    .rst         (rst),
    .p_in_SOF    (state_q == S_SEED),
    .p_in_en     (accept),
    .p_out_result(scr_byte)
  );

`ifdef TEST_TX_ERR_INJ_EN
  logic err_armed_q, err_armed_d;

  // One-shot arm; released when the corrupted first byte is taken by the MAC.
  always_comb begin
    err_armed_d = err_armed_q;
    if (err_armed_q) begin
      if (accept && first_byte) begin
        err_armed_d = 1'b0;
      end
    end else if (err_inj) begin
      err_armed_d = 1'b1;
    end
  end

  // Error-injection arm flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_armed_q <= 1'b0;
    end else begin
      err_armed_q <= err_armed_d;
    end
  end

  assign inj_bit = err_armed_q && (state_q == S_PAYLOAD) && first_byte;
`else
  assign inj_bit = 1'b0;
`endif

  // Frame sequencing: next state, length latch, byte and gap counters.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    byte_cnt_d  = byte_cnt_q;
    ifg_cnt_d   = ifg_cnt_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SEED;
        end
      end
      S_SEED: begin
        state_d    = S_PAYLOAD;
        len_d      = frame_len_eff;
        byte_cnt_d = 16'd0;
      end
      S_PAYLOAD: begin
        if (accept) begin
          if (last_byte) begin
            frame_cnt_d = frame_cnt_q + G_CNT_W'(1);
            ifg_cnt_d   = ifg_len;
            byte_cnt_d  = 16'd0;
            state_d     = S_GAP;
          end else begin
            byte_cnt_d = byte_cnt_q + 16'd1;
          end
        end
      end
      S_GAP: begin
        // Down-count to zero, so ifg_len = N yields N + 1 idle cycles.
        if (ifg_cnt_q == 8'd0) begin
          if (start) begin
            state_d    = S_PAYLOAD;
            len_d      = frame_len_eff;
            byte_cnt_d = 16'd0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          ifg_cnt_d = ifg_cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= 16'd1;
      byte_cnt_q  <= 16'd0;
      ifg_cnt_q   <= 8'd0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      ifg_cnt_q   <= ifg_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Outputs decode straight from registers, so reset clears them at once.
  assign mac_tx_valid = (state_q == S_PAYLOAD);
  assign mac_tx_sof   = mac_tx_valid && first_byte;
  assign mac_tx_eof   = mac_tx_valid && last_byte;
  assign mac_tx_data  = mac_tx_valid ? (scr_byte ^ {7'd0, inj_bit}) : 8'd0;
  assign busy         = (state_q != S_IDLE);
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_test_tx.sv
// Bench for test_tx: directed steps plus randomized traffic checked against a
// bit-stream model of the scrambler and a frame/gap bookkeeping model.
module tb_test_tx;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   frame_len;
  logic [7:0]    ifg_len;
  logic          rdy;
  logic [7:0]    mac_tx_data;
  logic          mac_tx_valid, mac_tx_sof, mac_tx_eof, busy;
  logic [CW-1:0] frame_cnt;
`ifdef TEST_TX_ERR_INJ_EN
  logic          err_inj;
`endif

  always #5 clk = ~clk;

  test_tx #(.G_INIT_VAL(16'h55AA), .G_CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
    .ifg_len(ifg_len),
`ifdef TEST_TX_ERR_INJ_EN
    .err_inj(err_inj),
`endif
    .mac_tx_data(mac_tx_data), .mac_tx_valid(mac_tx_valid),
    .mac_tx_sof(mac_tx_sof), .mac_tx_eof(mac_tx_eof), .mac_tx_rdy(rdy),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]    model_bytes [0:2047];
  int            idx, pos, exp_len, exp_ifg, gap_run;
  logic          in_gap, check_gap, frame_open, inj_model;
  logic [CW-1:0] frames;
  logic [15:0]   last_fl;
  logic          prev_valid, prev_rdy, prev_sof, prev_eof;
  logic [7:0]    prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scrambler stream as a bit sequence: x[n] = x[n-16]^x[n-15]^x[n-13]^x[n-4],
  // first 16 bits are the seed MSB-first; byte k bit i is x[8k+15-i].
  task automatic build_model();
    bit xs [0:16399];
    logic [15:0] sd;
    sd = 16'h55AA;
    for (int j = 0; j < 16; j++) xs[j] = sd[15-j];
    for (int n = 16; n < 16400; n++) xs[n] = xs[n-16] ^ xs[n-15] ^ xs[n-13] ^ xs[n-4];
    for (int k = 0; k < 2048; k++)
      for (int i = 0; i < 8; i++) model_bytes[k][i] = xs[8*k + 15 - i];
  endtask

  // One clock: check outputs at the falling edge, update the model, advance.
  task automatic tick();
    logic [7:0] edata;
    @(negedge clk);
    chk("frame_cnt", frame_cnt, frames);
    if (mac_tx_valid) begin
      if (!frame_open) begin
        exp_len = (last_fl == 16'd0) ? 1 : int'(last_fl);
        frame_open = 1'b1;
        if (in_gap && check_gap) chk("gap_len", gap_run, exp_ifg + 1);
        in_gap = 1'b0;
      end
      edata = model_bytes[idx];
      if (inj_model && pos == 0) edata = edata ^ 8'h01;
      chk("data", mac_tx_data, edata);
      chk("sof", mac_tx_sof, pos == 0);
      chk("eof", mac_tx_eof, pos == exp_len - 1);
      chk("busy_payload", busy, 1'b1);
      if (prev_valid && !prev_rdy) begin
        chk("stall_data", mac_tx_data, prev_data);
        chk("stall_flags", {mac_tx_sof, mac_tx_eof}, {prev_sof, prev_eof});
      end
      if (rdy) begin
        if (pos == 0) inj_model = 1'b0;
        idx++;
        pos++;
        if (pos == exp_len) begin
          pos = 0;
          frame_open = 1'b0;
          frames = frames + 1'b1;
          in_gap = 1'b1;
          check_gap = 1'b1;
          gap_run = 0;
          exp_ifg = int'(ifg_len);
        end
      end
    end else if (in_gap && busy) begin
      gap_run++;
    end
    prev_valid = mac_tx_valid;
    prev_rdy   = rdy;
    prev_data  = mac_tx_data;
    prev_sof   = mac_tx_sof;
    prev_eof   = mac_tx_eof;
    last_fl    = frame_len;
    @(posedge clk);
    #1;
  endtask

  // Start a session from IDLE: valid must appear on the 2nd edge, stream reseeds.
  task automatic start_session();
    idx = 0; pos = 0; frame_open = 1'b0; in_gap = 1'b0; check_gap = 1'b0;
    prev_valid = 1'b0;
    start = 1'b1;
    chk("lat_idle_busy", busy, 1'b0);
    @(posedge clk); #1;
    chk("lat_seed_busy", busy, 1'b1);
    chk("lat_seed_valid", mac_tx_valid, 1'b0);
    last_fl = frame_len;
    @(posedge clk); #1;
    chk("lat_payload_valid", mac_tx_valid, 1'b1);
  endtask

  task automatic run_frames(input int n);
    logic [CW-1:0] target;
    target = frames + CW'(n);
    for (int i = 0; i < 2000 && frames != target; i++) tick();
    chk("run_frames_bound", frames, target);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy; i++) tick();
    chk("idle_reached", busy, 1'b0);
    if (in_gap) chk("gap_to_idle", gap_run, exp_ifg + 1);
    in_gap = 1'b0;
  endtask

  initial begin
    logic [3:0]    pat;
    logic [CW-1:0] f0;
    int            i0;
    build_model();
    frames = '0; inj_model = 1'b0; exp_ifg = 0; gap_run = 0; exp_len = 1;
    rst = 1'b1; start = 1'b0; rdy = 1'b1; frame_len = 16'd4; ifg_len = 8'd3;
`ifdef TEST_TX_ERR_INJ_EN
    err_inj = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {mac_tx_valid, mac_tx_sof, mac_tx_eof, busy}, 4'b0000);
    chk("rst_frame_cnt", frame_cnt, '0);
    chk("rst_data", mac_tx_data, 8'h00);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_rst", busy, 1'b0);

    // Continuous 4-byte frames, ifg 3.
    frame_len = 16'd4; ifg_len = 8'd3; rdy = 1'b1;
    start_session();
    run_frames(3);
    start = 1'b0;
    wait_idle();
    chk("t2_frame_cnt", frame_cnt, CW'(3));

    // Zero and one byte lengths give sof=eof frames.
    frame_len = 16'd0; ifg_len = 8'd0;
    start_session();
    run_frames(2);
    frame_len = 16'd1;
    run_frames(2);
    start = 1'b0;
    wait_idle();

    // Back-pressure with rdy 1,0,0,1.
    frame_len = 16'd8; ifg_len = 8'd2; pat = 4'b1001;
    start_session();
    i0 = idx;
    f0 = frames;
    for (int k = 0; k < 400 && frames == f0; k++) begin
      rdy = pat[3 - (k % 4)];
      tick();
    end
    start = 1'b0; rdy = 1'b1;
    chk("t4_accepted", idx - i0, 8);
    wait_idle();

    // start dropped on byte 2 of a 6-byte frame; mid-frame length change ignored.
    frame_len = 16'd6; ifg_len = 8'd1;
    f0 = frames;
    start_session();
    for (int k = 0; k < 50 && pos != 2; k++) tick();
    start = 1'b0;
    frame_len = 16'd2;
    wait_idle();
    chk("t5_frame_cnt", frame_cnt, f0 + 1'b1);
    chk("t5_len_used", exp_len, 6);

    // Async reset mid-payload, then reseed.
    frame_len = 16'd6; ifg_len = 8'd2;
    start_session();
    repeat (3) tick();
    #2 rst = 1'b1; start = 1'b0;
    #1;
    chk("t1_async_outputs", {mac_tx_valid, mac_tx_sof, mac_tx_eof, busy}, 4'b0000);
    chk("t1_async_frame_cnt", frame_cnt, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    frames = '0;
    @(posedge clk); #1;
    frame_len = 16'd3;
    start_session();
    chk("t1_byte0", mac_tx_data, model_bytes[0]);
    run_frames(1);
    start = 1'b0;
    wait_idle();

`ifdef TEST_TX_ERR_INJ_EN
    // err_inj pulse in GAP corrupts bit 0 of the next first byte only.
    frame_len = 16'd4; ifg_len = 8'd5;
    start_session();
    run_frames(1);
    err_inj = 1'b1; inj_model = 1'b1;
    tick();
    err_inj = 1'b0;
    tick();
    err_inj = 1'b1;
    tick();
    err_inj = 1'b0;
    run_frames(2);
    chk("t6_inj_consumed", inj_model, 1'b0);
    start = 1'b0;
    wait_idle();
`endif

    // Randomized traffic: rdy, frame_len and ifg_len change every cycle.
    frame_len = 16'($urandom_range(0, 7));
    start_session();
    for (int k = 0; k < 700; k++) begin
      rdy       = ($urandom % 4) != 0;
      frame_len = 16'($urandom_range(0, 7));
      ifg_len   = 8'($urandom_range(0, 4));
      tick();
    end
    start = 1'b0; rdy = 1'b1;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
